// File: rtl/remote_comm_n.sv
// Host-side command link: sends a command byte plus DATA_BYTES payload bytes over 8N1 UART,
// then waits for a one-byte response with timeout and optional retransmission.
`timescale 1ns/1ps
module remote_comm_n #(
    parameter int BAUD_DIV     = 2604,
    parameter int DATA_BYTES   = 2,
    parameter int RESP_TIMEOUT = 1000000,
    parameter int MAX_RETRY    = 0,
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RX,
    output logic                    TX,
    input  logic [7:0]              cmd,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    send_cmd,
    output logic                    cmd_sent,
    output logic                    busy,
    output logic [7:0]              resp,
    output logic                    resp_rdy,
    input  logic                    clr_resp_rdy,
    output logic                    resp_timeout,
    output logic [RCW-1:0]          retry_cnt
);

    localparam int NB  = 1 + DATA_BYTES;
    localparam int BCW = $clog2(BAUD_DIV);
    localparam int TCW = $clog2(RESP_TIMEOUT + 1);
    localparam int BIW = $clog2(DATA_BYTES + 1);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    state_t          state_r, state_nx_s;
    logic [NB*8-1:0] shadow_r;
    logic [BIW-1:0]  byte_idx_r, sel_idx_s;
    logic [7:0]      byte_sel_s;
    logic [BCW-1:0]  tx_cnt_r;
    logic [3:0]      tx_bit_r;
    logic [8:0]      tx_frame_r;
    logic            tx_r;
    logic [TCW-1:0]  to_cnt_r;
    logic            cmd_sent_r, busy_r, resp_timeout_r;
    logic [RCW-1:0]  retry_cnt_r;

    logic            baud_end_s, frame_end_s, last_byte_s, timeout_s, can_retry_s;
    logic            latch_s, load_s, next_byte_s, enter_wait_s, retry_s, give_up_s;

    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t       rx_state_r;
    logic [BCW-1:0]  rx_cnt_r;
    logic [2:0]      rx_bit_r;
    logic [7:0]      rx_shift_r;
    logic [7:0]      resp_r;
    logic            resp_rdy_r, rx_done_r, rx_valid_s;

    assign baud_end_s  = (tx_cnt_r == BAUD_LAST);
    assign frame_end_s = (state_r == ST_SEND) && baud_end_s && (tx_bit_r == 4'd9);
    assign last_byte_s = (byte_idx_r == BIW'(DATA_BYTES));
    assign timeout_s   = (to_cnt_r == TCW'(RESP_TIMEOUT));
    assign can_retry_s = (MAX_RETRY > 0) && (retry_cnt_r != RCW'(MAX_RETRY));
    assign rx_valid_s  = (rx_state_r == RX_STOP) && (rx_cnt_r == BAUD_LAST) && rx_sync_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: if (send_cmd) state_nx_s = ST_LOAD; else state_nx_s = ST_IDLE;
            ST_LOAD: state_nx_s = ST_SEND;
            ST_SEND: if (frame_end_s && last_byte_s) state_nx_s = ST_WAIT; else state_nx_s = ST_SEND;
            ST_WAIT: begin
                if (rx_done_r)      state_nx_s = ST_IDLE;
                else if (timeout_s) state_nx_s = can_retry_s ? ST_LOAD : ST_IDLE;
                else                state_nx_s = ST_WAIT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output strobes steering the datapath
    always_comb begin
        latch_s      = 1'b0;
        load_s       = 1'b0;
        next_byte_s  = 1'b0;
        enter_wait_s = 1'b0;
        retry_s      = 1'b0;
        give_up_s    = 1'b0;
        case (state_r)
            ST_IDLE: latch_s = send_cmd;
            ST_LOAD: load_s  = 1'b1;
            ST_SEND: begin
                next_byte_s  = frame_end_s && !last_byte_s;
                enter_wait_s = frame_end_s && last_byte_s;
            end
            ST_WAIT: begin
                retry_s   = !rx_done_r && timeout_s && can_retry_s;
                give_up_s = !rx_done_r && timeout_s && !can_retry_s;
            end
            default: latch_s = 1'b0;
        endcase
    end

    // Byte selector: LOAD always picks the command byte, later frames the following byte
    always_comb begin
        sel_idx_s  = load_s ? {BIW{1'b0}} : byte_idx_r + BIW'(1);
        byte_sel_s = shadow_r[NB*8-1 -: 8];
        for (int k = 0; k < NB; k++) begin
            if (sel_idx_s == BIW'(k)) byte_sel_s = shadow_r[(NB-1-k)*8 +: 8];
            else                      byte_sel_s = byte_sel_s;
        end
    end

    // Transaction bookkeeping: shadow packet, status flags, timeout and retry counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r       <= {(NB*8){1'b0}};
            busy_r         <= 1'b0;
            cmd_sent_r     <= 1'b0;
            resp_timeout_r <= 1'b0;
            retry_cnt_r    <= {RCW{1'b0}};
            to_cnt_r       <= {TCW{1'b0}};
            byte_idx_r     <= {BIW{1'b0}};
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            if (latch_s) shadow_r <= {cmd, data};
            if (latch_s || retry_s)  cmd_sent_r <= 1'b0;
            else if (enter_wait_s)   cmd_sent_r <= 1'b1;
            if (latch_s)             resp_timeout_r <= 1'b0;
            else if (give_up_s)      resp_timeout_r <= 1'b1;
            if (latch_s)             retry_cnt_r <= {RCW{1'b0}};
            else if (retry_s)        retry_cnt_r <= retry_cnt_r + RCW'(1);
            if (enter_wait_s)        to_cnt_r <= {TCW{1'b0}};
            else if (state_r == ST_WAIT && !timeout_s) to_cnt_r <= to_cnt_r + TCW'(1);
            if (load_s)              byte_idx_r <= {BIW{1'b0}};
            else if (next_byte_s)    byte_idx_r <= byte_idx_r + BIW'(1);
        end
    end

    // UART transmitter: frames run back-to-back, line held high outside SEND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r       <= 1'b1;
            tx_cnt_r   <= {BCW{1'b0}};
            tx_bit_r   <= 4'd0;
            tx_frame_r <= 9'h1FF;
        end else if (load_s) begin
            tx_r       <= 1'b0;
            tx_cnt_r   <= {BCW{1'b0}};
            tx_bit_r   <= 4'd0;
            tx_frame_r <= {1'b1, byte_sel_s};
        end else if (state_r == ST_SEND) begin
            if (baud_end_s) begin
                tx_cnt_r <= {BCW{1'b0}};
                if (tx_bit_r == 4'd9) begin
                    tx_bit_r <= 4'd0;
                    if (last_byte_s) begin
                        tx_r <= 1'b1;
                    end else begin
                        tx_r       <= 1'b0;
                        tx_frame_r <= {1'b1, byte_sel_s};
                    end
                end else begin
                    tx_bit_r   <= tx_bit_r + 4'd1;
                    tx_r       <= tx_frame_r[0];
                    tx_frame_r <= {1'b1, tx_frame_r[8:1]};
                end
            end else begin
                tx_cnt_r <= tx_cnt_r + BCW'(1);
            end
        end else begin
            tx_r <= 1'b1;
        end
    end

    // UART receiver: mid-bit sampling, start-glitch rejection, framing errors dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= {BCW{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            resp_r     <= 8'h00;
            resp_rdy_r <= 1'b0;
            rx_done_r  <= 1'b0;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            rx_done_r <= rx_valid_s;
            if (rx_valid_s) begin
                resp_r     <= rx_shift_r;
                resp_rdy_r <= 1'b1;
            end else if (clr_resp_rdy) begin
                resp_rdy_r <= 1'b0;
            end
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= {BCW{1'b0}};
                    if (!rx_sync_r && rx_prev_r) rx_state_r <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_r == BAUD_HALF) begin
                        rx_cnt_r   <= {BCW{1'b0}};
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + BCW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BAUD_LAST) begin
                        rx_cnt_r   <= {BCW{1'b0}};
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                        if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + BCW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BAUD_LAST) begin
                        rx_cnt_r   <= {BCW{1'b0}};
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + BCW'(1);
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    assign TX           = tx_r;
    assign cmd_sent     = cmd_sent_r;
    assign busy         = busy_r;
    assign resp         = resp_r;
    assign resp_rdy     = resp_rdy_r;
    assign resp_timeout = resp_timeout_r;
    assign retry_cnt    = retry_cnt_r;

endmodule

// File: tb/tb_remote_comm_n.sv
// Directed self-checking bench for remote_comm_n: two instances (2-byte with retries, 4-byte without).
`timescale 1ns/1ps
module tb_remote_comm_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_a = 1'b1, rx_b = 1'b1;
    logic        tx_a, tx_b;
    logic [7:0]  cmd_a = 8'h00, cmd_b = 8'h00;
    logic [15:0] data_a = 16'h0000;
    logic [31:0] data_b = 32'h0;
    logic        send_a = 1'b0, send_b = 1'b0;
    logic        cs_a, cs_b, busy_a, busy_b;
    logic [7:0]  resp_a, resp_b;
    logic        rdy_a, rdy_b;
    logic        clr_a = 1'b0, clr_b = 1'b0;
    logic        to_a, to_b;
    logic [1:0]  rc_a;
    logic [0:0]  rc_b;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    remote_comm_n #(.BAUD_DIV(8), .DATA_BYTES(2), .RESP_TIMEOUT(2000), .MAX_RETRY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .RX(rx_a), .TX(tx_a), .cmd(cmd_a), .data(data_a),
        .send_cmd(send_a), .cmd_sent(cs_a), .busy(busy_a), .resp(resp_a), .resp_rdy(rdy_a),
        .clr_resp_rdy(clr_a), .resp_timeout(to_a), .retry_cnt(rc_a));

    remote_comm_n #(.BAUD_DIV(8), .DATA_BYTES(4), .RESP_TIMEOUT(2000), .MAX_RETRY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .RX(rx_b), .TX(tx_b), .cmd(cmd_b), .data(data_b),
        .send_cmd(send_b), .cmd_sent(cs_b), .busy(busy_b), .resp(resp_b), .resp_rdy(rdy_b),
        .clr_resp_rdy(clr_b), .resp_timeout(to_b), .retry_cnt(rc_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Pulses send_cmd; returns at the negedge of the first start-bit cycle.
    task automatic start_tx(input bit sel, input logic [7:0] c, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin cmd_b = c; data_b = d; send_b = 1'b1; end
        else begin cmd_a = c; data_a = d[15:0]; send_a = 1'b1; end
        @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
        check("busy_cycle1", 64'(sel ? busy_b : busy_a), 64'd1);
        check("tx_idle_in_load", 64'(sel ? tx_b : tx_a), 64'd1);
        check("cmd_sent_cleared", 64'(sel ? cs_b : cs_a), 64'd0);
        check("timeout_cleared", 64'(sel ? to_b : to_a), 64'd0);
        check("retry_cleared", 64'(sel ? 2'(rc_b) : rc_a), 64'd0);
        @(negedge clk);
    endtask

    // Samples every bit mid-period from the first start-bit cycle, then checks cmd_sent timing.
    task automatic check_packet(input bit sel, input int n, input logic [39:0] exp);
        logic [9:0] fr;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 10; j++) begin
                fr[j] = sel ? tx_b : tx_a;
                if (!(k == n - 1 && j == 9)) repeat (8) @(negedge clk);
            end
            check("tx_frame", 64'(fr), 64'({1'b1, exp[39-8*k -: 8], 1'b0}));
        end
        repeat (3) @(negedge clk);
        check("cmd_sent_before", 64'(sel ? cs_b : cs_a), 64'd0);
        @(negedge clk);
        check("cmd_sent_rise", 64'(sel ? cs_b : cs_a), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = b[i];
            repeat (8) @(negedge clk);
        end
        rx_a = stop;
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
    endtask

    task automatic wait_rdy(input logic [7:0] exp);
        bit found = 1'b0;
        int i = 0;
        while (!found && i < 300) begin
            @(negedge clk);
            found = rdy_a;
            i++;
        end
        check("resp_rdy_seen", 64'(found), 64'd1);
        check("resp_value", 64'(resp_a), 64'(exp));
        check("busy_at_rdy", 64'(busy_a), 64'd1);
        @(negedge clk);
        check("busy_after_rdy", 64'(busy_a), 64'd0);
        check("timeout_low", 64'(to_a), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx_a), 64'd1);
        check("rst_cmd_sent", 64'(cs_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_resp", 64'(resp_a), 64'd0);
        check("rst_resp_rdy", 64'(rdy_a), 64'd0);
        check("rst_timeout", 64'(to_a), 64'd0);
        check("rst_retry", 64'(rc_a), 64'd0);
        rst_n = 1'b1;

        // 1: basic packet plus loopback response
        start_tx(1'b0, 8'h05, 32'h1234);
        check_packet(1'b0, 3, {8'h05, 8'h12, 8'h34, 16'h0});
        fork
            send_byte(8'hA5, 1'b1);
            wait_rdy(8'hA5);
        join

        // 2: no responder, two retries then give up
        start_tx(1'b0, 8'h21, 32'hBEEF);
        for (int r = 0; r < 3; r++) begin
            check_packet(1'b0, 3, {8'h21, 8'hBE, 8'hEF, 16'h0});
            check("retry_in_wait", 64'(rc_a), 64'(r));
            repeat (2000) @(negedge clk);
            check("busy_before_to", 64'(busy_a), 64'd1);
            check("cmd_sent_held", 64'(cs_a), 64'd1);
            check("timeout_not_yet", 64'(to_a), 64'd0);
            @(negedge clk);
            if (r < 2) begin
                check("retry_inc", 64'(rc_a), 64'(r + 1));
                check("cmd_sent_retry_clr", 64'(cs_a), 64'd0);
                check("busy_in_retry", 64'(busy_a), 64'd1);
                @(negedge clk);
            end
        end
        check("timeout_set", 64'(to_a), 64'd1);
        check("busy_after_to", 64'(busy_a), 64'd0);
        check("retry_final", 64'(rc_a), 64'd2);

        // 3: four data bytes, extra send_cmd pulses ignored, no retry allowed
        start_tx(1'b1, 8'h06, 32'hDEADBEEF);
        fork
            check_packet(1'b1, 5, {8'h06, 32'hDEADBEEF});
            begin
                repeat (30) @(negedge clk);
                cmd_b = 8'hFF; data_b = 32'h0; send_b = 1'b1;
                @(negedge clk);
                send_b = 1'b0;
                repeat (200) @(negedge clk);
                send_b = 1'b1;
                @(negedge clk);
                send_b = 1'b0;
            end
        join
        repeat (2000) @(negedge clk);
        check("b_timeout_not_yet", 64'(to_b), 64'd0);
        @(negedge clk);
        check("b_timeout_set", 64'(to_b), 64'd1);
        check("b_busy_low", 64'(busy_b), 64'd0);
        check("b_retry_zero", 64'(rc_b), 64'd0);
        repeat (20) @(negedge clk);
        check("b_no_resend", 64'(tx_b), 64'd1);

        // 4: framing error discarded, set beats simultaneous clear
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("rdy_cleared", 64'(rdy_a), 64'd0);
        start_tx(1'b0, 8'h11, 32'hABCD);
        check_packet(1'b0, 3, {8'h11, 8'hAB, 8'hCD, 16'h0});
        clr_a = 1'b1;
        send_byte(8'h96, 1'b0);
        check("frame_err_no_rdy", 64'(rdy_a), 64'd0);
        check("frame_err_resp", 64'(resp_a), 64'hA5);
        check("frame_err_busy", 64'(busy_a), 64'd1);
        @(negedge clk);
        fork
            send_byte(8'h3C, 1'b1);
            wait_rdy(8'h3C);
        join
        check("clr_after_set", 64'(rdy_a), 64'd0);
        clr_a = 1'b0;

        // 5: start glitch rejected; reset mid-packet then a clean packet
        rx_a = 1'b0;
        repeat (2) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rdy", 64'(rdy_a), 64'd0);
        check("glitch_resp", 64'(resp_a), 64'h3C);
        start_tx(1'b0, 8'h07, 32'h0102);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 64'(tx_a), 64'd1);
        check("mid_rst_busy", 64'(busy_a), 64'd0);
        check("mid_rst_resp", 64'(resp_a), 64'd0);
        check("mid_rst_cmd_sent", 64'(cs_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_tx(1'b0, 8'h07, 32'h9A6B);
        check_packet(1'b0, 3, {8'h07, 8'h9A, 8'h6B, 16'h0});
        fork
            send_byte(8'h5A, 1'b1);
            wait_rdy(8'h5A);
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/remote_comm_n.md
# remote_comm_n

Parametrised host-side command link, successor to the fixed two-byte remote comm model. On a strobe it serialises one command byte plus `DATA_BYTES` data bytes over an 8N1 UART. It then waits for a one-byte response from the quadcopter, with a response timeout and automatic retransmission. It sits between test/host logic and the copter's `RX`/`TX` pins and is synthesisable, so it can also act as a ground-station bridge.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clocks per UART bit; legal range ≥ 4.
- `DATA_BYTES`, default 2: data bytes following the command byte; legal range 1–4.
- `RESP_TIMEOUT`, default 1000000: clocks to wait for a response after the last stop bit.
- `MAX_RETRY`, default 0: retransmissions attempted after a timeout before giving up.

Ports (clock and reset first):
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `RX`, in, 1: serial in from the copter's TX; asynchronous to `clk`.
- `TX`, out, 1: serial out to the copter's RX.
- `cmd`, in, 8: command byte.
- `data`, in, 8*DATA_BYTES: payload, sent most-significant byte first.
- `send_cmd`, in, 1: one-cycle start strobe.
- `cmd_sent`, out, 1: level; the last frame of the packet has been transmitted.
- `busy`, out, 1: a transaction (send, wait or retry) is in progress.
- `resp`, out, 8: last received byte.
- `resp_rdy`, out, 1: level; `resp` is valid.
- `clr_resp_rdy`, in, 1: clears `resp_rdy`.
- `resp_timeout`, out, 1: level; the transaction ended with no response.
- `retry_cnt`, out, $clog2(MAX_RETRY+1) (min 1): retries used in the current or last transaction.

## Operation
- **Reset values:** `TX`=1, `cmd_sent`=0, `busy`=0, `resp`=8'h00, `resp_rdy`=0, `resp_timeout`=0, `retry_cnt`=0; FSM in IDLE; the receiver is idle.
- **FSM states:** IDLE → LOAD → SEND → WAIT → (IDLE | LOAD).
- **IDLE:**
  - `send_cmd`=1 latches `cmd` and `data` into a (1+DATA_BYTES)-byte shadow register.
  - The same cycle clears `cmd_sent`, `resp_timeout` and `retry_cnt`, and goes to LOAD.
  - `send_cmd` outside IDLE is ignored.
- **LOAD:** selects the next byte (command first, then data MSB first) into the TX shift register, then goes to SEND.
- **SEND:**
  - Each frame is a start bit (0), 8 data bits LSB first, then a stop bit (1), each held BAUD_DIV clocks.
  - Frames are back-to-back with no idle gap.
  - After the stop bit of the last byte: set `cmd_sent`, clear the timeout counter, go to WAIT.
- **WAIT:**
  - A received valid byte returns the FSM to IDLE with `resp_timeout`=0.
  - If the counter reaches RESP_TIMEOUT and `retry_cnt` < MAX_RETRY: increment `retry_cnt`, clear `cmd_sent`, return to LOAD and retransmit the identical latched packet.
  - Otherwise: set `resp_timeout` and go to IDLE.
- **Receiver:** runs independently of the FSM.
  - `RX` is double-flopped before use.
  - A falling edge while the receiver is idle starts a frame; the start bit is re-sampled at BAUD_DIV/2, and a high sample aborts the frame as a glitch.
  - Each subsequent bit is sampled every BAUD_DIV clocks.
  - Stop bit 1: load `resp` and set `resp_rdy`. Stop bit 0 (framing error): discard the byte; `resp` and `resp_rdy` are unchanged.
- **`resp_rdy`:**
  - Set by any valid byte, including one arriving while IDLE (a stray response).
  - If a set and `clr_resp_rdy` occur in the same cycle, the set wins.
  - Only a byte completed in WAIT ends the transaction.
- **Reset mid-operation:** returns all outputs to their reset values immediately; `TX` goes high, truncating any frame in progress.

## Timing
- `send_cmd` sampled at cycle 0 → `busy`=1 at cycle 1; the `TX` start-bit edge follows LOAD at cycle 2.
- Packet duration: 10·BAUD_DIV·(1+DATA_BYTES) clocks.
- `cmd_sent` rises exactly one cycle after the last stop bit's final clock.
- The timeout counter counts from the cycle `cmd_sent` rises; timeout fires at count RESP_TIMEOUT.
- Valid-byte to `resp_rdy`: one cycle after the stop-bit sample.
- `busy` falls in the cycle after `resp_rdy` rises (in WAIT) or in the cycle `resp_timeout` rises.
- Each retry costs one LOAD cycle plus a full packet duration.
- Widths: the baud counter is $clog2(BAUD_DIV) bits; the timeout counter is $clog2(RESP_TIMEOUT+1) bits and saturates; the byte index is $clog2(DATA_BYTES+1) bits.

## Test plan
All scenarios use BAUD_DIV=8 and RESP_TIMEOUT=2000.

1. DATA_BYTES=2, `cmd`=8'h05, `data`=16'h1234 → `TX` carries 05, 12, 34 over 240 clocks; `cmd_sent` rises one clock later. Loopback responder returns 8'hA5 → `resp`=A5, `resp_rdy`=1, `busy`=0.
2. No responder, MAX_RETRY=2 → three identical packets on `TX`, `retry_cnt` goes 0→1→2, then `resp_timeout`=1 with `busy`=0.
3. DATA_BYTES=4, `data`=32'hDEADBEEF → byte order 06, DE, AD, BE, EF on `TX`; second `send_cmd` pulses during SEND are ignored, with no packet change.
4. Responder sends a byte with stop bit 0, then 8'h3C → the first byte is discarded and `resp`=3C. `clr_resp_rdy` asserted in the same cycle as the set → `resp_rdy` stays 1.
5. A 2-clock low glitch on `RX` in IDLE → no `resp_rdy`. `rst_n` pulsed low mid-packet → all outputs at reset values, `TX`=1; the next `send_cmd` transmits normally.
